mem_bridge: RTL and testbench

Memory-side responder for the multi-cycle core's WB-phase load/store requests. Accepts the controller's `mem_read` / `mem_write` / `mem_wrbits` / address, and runs one transaction on a word-wide external req/ack bus. Replicates store data onto the selected byte lanes and returns the raw read word. Holds `busy` high so phasegen stalls in WB until the bus acknowledges or a timeout fires.

---
 rtl/kappa3_mem_pkg.sv | 20 ++
 rtl/mem_lane_rep.sv | 31 +++
 rtl/mem_bridge.sv | 127 ++++++++++++
 tb/tb_mem_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kappa3_mem_pkg.sv
// Shared types and constants for the WB-phase memory bridge.
// Covers the FSM state encoding, the default timeout and the byte-enable patterns.
package kappa3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int         TIMEOUT_DEFAULT = 255;
  localparam logic [3:0] BE_WORD         = 4'b1111;
  localparam logic [3:0] BE_HALF_LO      = 4'b0011;
  localparam logic [3:0] BE_HALF_HI      = 4'b1100;

  function automatic logic is_onehot4(input logic [3:0] m);
    return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) || (m == 4'b1000);
  endfunction

endpackage

// File: rtl/mem_lane_rep.sv
// Classifies a store's byte-lane mask and replicates right-aligned store data onto the lanes.
// Loads and unsupported masks fall back to a full-word access; bad_mask flags the latter.
module mem_lane_rep
  import kappa3_mem_pkg::*;
(
  input  logic        is_write,
  input  logic [3:0]  wrbits,
  input  logic [31:0] wrdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        bad_mask
);

  always_comb begin
    wdata    = wrdata;
    be       = BE_WORD;
    bad_mask = 1'b0;
    if (is_write) begin
      if (is_onehot4(wrbits)) begin
        be    = wrbits;
        wdata = {4{wrdata[7:0]}};
      end else if ((wrbits == BE_HALF_LO) || (wrbits == BE_HALF_HI)) begin
        be    = wrbits;
        wdata = {2{wrdata[15:0]}};
      end else if (wrbits != BE_WORD) begin
        bad_mask = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Runs one req/ack bus transaction per WB-phase load/store and stalls the core via busy.
// A REQ phase with no ack for TIMEOUT cycles aborts with a sticky error and a zero read word.
module mem_bridge
  import kappa3_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wrbits,
  input  logic [31:0] addr,
  input  logic [31:0] wrdata,
  output logic [31:0] rddata,
  output logic        busy,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rddata;
  logic [3:0]  r_be;

  logic        w_req_in;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_bad_mask;
  logic        w_unused_addr;

  assign w_req_in      = mem_read | mem_write;
  assign w_timeout     = (r_cnt == CNT_LAST);
  assign w_unused_addr = ^addr[1:0];

  mem_lane_rep u_lane_rep (
    .is_write (mem_write),
    .wrbits   (mem_wrbits),
    .wrdata   (wrdata),
    .wdata    (w_wdata),
    .be       (w_be),
    .bad_mask (w_bad_mask)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    bus_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = w_req_in;
        if (w_req_in) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || w_timeout) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Ack is tested before the timeout so an ack on the final allowed cycle completes cleanly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rddata <= '0;
      r_be     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_in) begin
            r_we    <= mem_write;
            r_addr  <= {addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            if (w_bad_mask || (mem_read && mem_write)) r_err <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            if (!r_we) r_rddata <= bus_rdata;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_rddata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rddata    = r_rddata;
  assign err       = r_err;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases followed by randomized loads/stores,
// compared against a transaction-level model of lanes, latency, read data and sticky error.
module tb_mem_bridge;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wrbits = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] rddata;
  logic        busy;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rddata = '0;

  always #5 clock = ~clock;

  mem_bridge #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wrbits(mem_wrbits),
    .addr      (addr),
    .wrdata    (wrdata),
    .rddata    (rddata),
    .busy      (busy),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Lane rules stated directly: one byte, an aligned half, the full word, or anything else.
  function automatic void model_lanes(input logic wr, input logic [3:0] m, input logic [31:0] d,
                                      output logic [3:0] be, output logic [31:0] wd, output logic bad);
    bad = 1'b0;
    be  = 4'hF;
    wd  = d;
    if (wr) begin
      if ($countones(m) == 1) begin
        be = m;
        wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end else if (m == 4'b0011 || m == 4'b1100) begin
        be = m;
        wd = {d[15:0], d[15:0]};
      end else if (m != 4'hF) begin
        bad = 1'b1;
      end
    end
  endfunction

  // Called at a negedge with the bridge idle; returns at a negedge after DONE.
  task automatic do_txn(input string name, input logic rd, input logic wr, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d, input int ack_at,
                        input logic [31:0] ack_data);
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        bad;
    bit          tmo;
    int          e_req;
    int          nreq;
    int          nbusy;
    bit          done;
    model_lanes(wr, m, d, e_be, e_wd, bad);
    tmo   = (ack_at > TO);
    e_req = tmo ? TO : ack_at;
    nreq  = 0;
    nbusy = 0;
    done  = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    mem_wrbits = m;
    addr       = a;
    wrdata     = d;
    bus_ack    = 1'b0;
    for (int cyc = 0; cyc < TO + 10 && !done; cyc++) begin
      #1;
      if (busy) nbusy++;
      if (bus_req) begin
        nreq++;
        check_val({name, ".bus_addr"}, bus_addr, a & ~32'h3);
        check_val({name, ".bus_be"}, {28'd0, bus_be}, {28'd0, e_be});
        check_val({name, ".bus_we"}, {31'd0, bus_we}, {31'd0, wr});
        if (wr) check_val({name, ".bus_wdata"}, bus_wdata, e_wd);
      end else if (cyc > 0) begin
        done = 1'b1;
        if (tmo) begin
          exp_err    = 1'b1;
          exp_rddata = '0;
        end else if (!wr) begin
          exp_rddata = ack_data;
        end
        if (bad || (rd && wr)) exp_err = 1'b1;
        check_val({name, ".rddata"}, rddata, exp_rddata);
        check_val({name, ".err"}, {31'd0, err}, {31'd0, exp_err});
        check_val({name, ".busy_done"}, {31'd0, busy}, 32'd0);
        check_val({name, ".req_cycles"}, nreq, e_req);
        check_val({name, ".busy_cycles"}, nbusy, e_req + 1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      bus_ack   = bus_req && (nreq == ack_at);
      bus_rdata = bus_ack ? ack_data : $urandom;
      @(negedge clock);
    end
    bus_ack = 1'b0;
    if (!done) begin
      check_val({name, ".completed"}, 32'd0, 32'd1);
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    $display("txn %s rd=%0b wr=%0b mask=%b addr=%h wdata=%h ack_at=%0d rddata=%h err=%0b",
             name, rd, wr, m, a, d, ack_at, rddata, err);
  endtask

  task automatic idle_ack();
    bus_ack   = 1'b1;
    bus_rdata = $urandom;
    #1;
    check_val("idle_ack.bus_req", {31'd0, bus_req}, 32'd0);
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    check_val("idle_ack.bus_req_after", {31'd0, bus_req}, 32'd0);
    check_val("idle_ack.rddata", rddata, exp_rddata);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset      = 1'b1;
    exp_err    = 1'b0;
    exp_rddata = '0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd;
    logic        wr;
    logic [3:0]  m;
    int          kind;
    #2;
    check_val("rst.busy", {31'd0, busy}, 32'd0);
    check_val("rst.bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rst.err", {31'd0, err}, 32'd0);
    check_val("rst.rddata", rddata, 32'd0);
    check_val("rst.bus_addr", bus_addr, 32'd0);
    check_val("rst.bus_be", {28'd0, bus_be}, 32'd0);
    check_val("rst.bus_we", {31'd0, bus_we}, 32'd0);
    check_val("rst.bus_wdata", bus_wdata, 32'd0);
    mem_read = 1'b1;
    #1;
    check_val("rst.busy_req_in", {31'd0, busy}, 32'd1);
    mem_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    do_txn("LW", 1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 3, 32'hDEADBEEF);
    do_txn("SB", 1'b0, 1'b1, 4'b1000, 32'h203, 32'h000000A5, 1, 32'h0);
    do_txn("SH", 1'b0, 1'b1, 4'b1100, 32'h10, 32'h00001234, 2, 32'h0);
    do_txn("TMO", 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, TO + 5, 32'h0);
    do_txn("LW_after_tmo", 1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 2, 32'h11112222);

    // Abort a read in its second REQ cycle with the request already withdrawn.
    mem_read = 1'b1;
    addr     = 32'h300;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_val("rstmid.bus_req_before", {31'd0, bus_req}, 32'd1);
    mem_read = 1'b0;
    reset    = 1'b0;
    #1;
    check_val("rstmid.bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rstmid.busy", {31'd0, busy}, 32'd0);
    check_val("rstmid.err", {31'd0, err}, 32'd0);
    @(negedge clock);
    reset      = 1'b1;
    exp_err    = 1'b0;
    exp_rddata = '0;
    @(negedge clock);

    do_txn("SW_clean", 1'b0, 1'b1, 4'hF, 32'h500, 32'hCAFEF00D, 1, 32'h0);
    do_txn("RW_both", 1'b1, 1'b1, 4'hF, 32'h600, 32'h55, 1, 32'h0);
    apply_reset();
    do_txn("LW_ack_last", 1'b1, 1'b0, 4'hF, 32'h704, 32'h0, TO, 32'h0BADF00D);
    idle_ack();
    do_txn("SW_bad_mask", 1'b0, 1'b1, 4'b0101, 32'h800, 32'h87654321, 2, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) apply_reset();
      kind = $urandom_range(0, 9);
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      m    = 4'($urandom_range(1, 15));
      do_txn($sformatf("rnd%0d", i), rd, wr, m, $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom);
      if ($urandom_range(0, 3) == 0) idle_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
